// File: rtl/tff_sweep_ctrl.sv
// Sweeps {a,b,c,d} through minterms 0..15. Each minterm clears an owned T flip-flop,
// lets it toggle from t_in for HOLD cycles, then captures q into a 16-bit response map.
module tff_sweep_ctrl #(
  parameter int HOLD = 1
) (
  input  logic        i_clk,
  input  logic        i_clr_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_exp,
  input  logic        i_t_in,
  output logic [3:0]  o_abcd,
  output logic [3:0]  o_m,
  output logic        o_q,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_resp,
  output logic        o_pass
);

  if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
    $error("tff_sweep_ctrl: HOLD must be in 1..15");
  end

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_TOGGLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_m;
  logic [3:0]  r_abcd;
  logic        r_q;
  logic [3:0]  r_cnt;
  logic [15:0] r_resp;
  logic [15:0] r_exp;
  logic        r_pass;

  logic        w_busy;
  logic        w_abort;
  logic        w_last_tog;
  logic        w_last_m;
  logic [15:0] w_resp_final;

  assign w_busy       = (r_state == S_CLEAR) || (r_state == S_TOGGLE) || (r_state == S_SAMPLE);
  assign w_abort      = i_abort && w_busy;
  assign w_last_tog   = (r_cnt == HOLD_M1);
  assign w_last_m     = (r_m == 4'd15);
  // The final SAMPLE writes bit 15 on the same edge pass is computed, so fold q in directly.
  assign w_resp_final = {r_q, r_resp[14:0]};

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (i_start) w_next = S_CLEAR;
      S_CLEAR:  w_next = w_abort ? S_IDLE : S_TOGGLE;
      S_TOGGLE: begin
        if (w_abort)         w_next = S_IDLE;
        else if (w_last_tog) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (w_abort)       w_next = S_IDLE;
        else if (w_last_m) w_next = S_DONE;
        else               w_next = S_CLEAR;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // An abort suppresses every datapath update on its edge so captured state freezes.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_m    <= '0;
      r_abcd <= '0;
      r_q    <= 1'b0;
      r_cnt  <= '0;
      r_resp <= '0;
      r_exp  <= '0;
      r_pass <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_m    <= '0;
            r_abcd <= '0;
            r_resp <= '0;
            r_exp  <= i_exp;
            r_pass <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (!w_abort) begin
            r_q   <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_TOGGLE: begin
          if (!w_abort) begin
            r_q   <= r_q ^ i_t_in;
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          if (!w_abort) begin
            r_resp[r_m] <= r_q;
            if (w_last_m) begin
              r_pass <= (w_resp_final == r_exp);
            end else begin
              r_m    <= r_m + 4'd1;
              r_abcd <= r_m + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_abcd = r_abcd;
  assign o_m    = r_m;
  assign o_q    = r_q;
  assign o_busy = w_busy;
  assign o_done = (r_state == S_DONE);
  assign o_resp = r_resp;
  assign o_pass = r_pass;

endmodule

// File: tb/tb_tff_sweep_ctrl.sv
// Bench for tff_sweep_ctrl: three instances (HOLD=1,2,3) driven from truth tables,
// checked against a net-toggle model of the sweep.
module tb_tff_sweep_ctrl;

  localparam int HV [3] = '{1, 2, 3};

  logic        clk;
  logic        clr_n [3];
  logic        start [3];
  logic        abort [3];
  logic [15:0] expv  [3];
  logic        t_in  [3];
  logic [15:0] tbl   [3];
  logic [3:0]  abcd  [3];
  logic [3:0]  m     [3];
  logic        q     [3];
  logic        busy  [3];
  logic        done  [3];
  logic [15:0] resp  [3];
  logic        pass  [3];

  int cmp  = 0;
  int errs = 0;

  typedef struct {
    int          busy_cnt;
    int          done_cnt;
    int          done_at;
    int          overlap;
    int          qerr;
    logic [15:0] resp_done;
    logic        pass_done;
    logic        busy_late;
    logic [15:0] s_resp;
    logic [3:0]  s_m;
    logic [3:0]  s_abcd;
    logic        s_q;
    logic        s_busy;
    logic        s_done;
    logic        s_pass;
  } obs_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign t_in[g] = tbl[g][abcd[g]];
    tff_sweep_ctrl #(.HOLD(HV[g])) u_dut (
      .i_clk  (clk),
      .i_clr_n(clr_n[g]),
      .i_start(start[g]),
      .i_abort(abort[g]),
      .i_exp  (expv[g]),
      .i_t_in (t_in[g]),
      .o_abcd (abcd[g]),
      .o_m    (m[g]),
      .o_q    (q[g]),
      .o_busy (busy[g]),
      .o_done (done[g]),
      .o_resp (resp[g]),
      .o_pass (pass[g])
    );
  end

  // Odd number of toggles leaves q = t_in, even leaves q = 0.
  function automatic logic [15:0] model(input logic [15:0] f, input int h);
    return (h % 2 == 1) ? f : 16'h0000;
  endfunction

  function automatic logic [15:0] spec_fn();
    logic [15:0] f;
    logic a, b, c, d;
    for (int k = 0; k < 16; k++) begin
      a = k[3]; b = k[2]; c = k[1]; d = k[0];
      f[k] = (a & ~c & ~d) | (b & c & d);
    end
    return f;
  endfunction

  // Pulse (or hold) start, then observe a bounded window of n+3 cycles.
  task automatic run(input int g, input logic [15:0] f, input logic [15:0] e, input bit keep,
                     input int ab_c, input int rs_c, output obs_t o);
    int   h = HV[g];
    int   n = 16 * (HV[g] + 2);
    int   stop = -1;
    int   snap_c = 16 * (HV[g] + 2) + 1;
    int   k, p;
    logic qe;
    o = '{default: 0};
    tbl[g] = f; expv[g] = e; start[g] = 1'b1;
    @(posedge clk); #1;
    if (!keep) start[g] = 1'b0;
    for (int c = 0; c < n + 3; c++) begin
      if (c <= n + 1 && busy[g]) o.busy_cnt++;
      if (c <= n + 1 && done[g]) begin
        o.done_cnt++; o.done_at = c; o.resp_done = resp[g]; o.pass_done = pass[g];
      end
      if (busy[g] && done[g]) o.overlap++;
      if (c == n + 2) o.busy_late = busy[g];
      if (c == snap_c) begin
        o.s_resp = resp[g]; o.s_m = m[g]; o.s_abcd = abcd[g]; o.s_q = q[g];
        o.s_busy = busy[g]; o.s_done = done[g]; o.s_pass = pass[g];
      end
      if (stop < 0 && c < n) begin
        k = c / (h + 2);
        p = c % (h + 2);
        if (int'(m[g]) != k || int'(abcd[g]) != k) o.qerr++;
        if (p >= 1 || k > 0) begin
          qe = (p >= 1) ? (f[k] & (((p - 1) % 2) == 1)) : (f[k-1] & (h % 2 == 1));
          if (q[g] !== qe) o.qerr++;
        end
      end
      abort[g] = (c == ab_c);
      clr_n[g] = (c != rs_c);
      if ((c == ab_c || c == rs_c) && c < n) begin
        stop = c; snap_c = c + 1;
      end
      @(posedge clk); #1;
    end
    abort[g] = 1'b0; clr_n[g] = 1'b1;
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      clr_n[g] = 1'b0; start[g] = 1'b1; abort[g] = 1'b1; expv[g] = 16'hFFFF; tbl[g] = 16'hFFFF;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      cmp++;
      if ({resp[g], m[g], abcd[g], q[g], busy[g], done[g], pass[g]} !== 31'd0) begin
        errs++;
        $display("FAIL reset g=%0d got resp=%h m=%0d abcd=%0d q=%b busy=%b done=%b pass=%b want all 0",
                 g, resp[g], m[g], abcd[g], q[g], busy[g], done[g], pass[g]);
      end
      start[g] = 1'b0; abort[g] = 1'b0; clr_n[g] = 1'b1; tbl[g] = 16'h0000;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_spec_sweeps();
    obs_t        o;
    logic [15:0] f = spec_fn();
    logic [15:0] wr [3] = '{16'h9180, 16'h0000, 16'hFFFF};
    logic        wp [3] = '{1'b1, 1'b0, 1'b1};
    for (int g = 0; g < 3; g++) begin
      run(g, (g == 2) ? 16'hFFFF : f, (g == 2) ? 16'hFFFF : 16'h9180, 1'b0, -1, -1, o);
      cmp++;
      if (o.resp_done !== wr[g] || o.pass_done !== wp[g]) begin
        errs++;
        $display("FAIL spec_resp g=%0d got resp=%h pass=%b want resp=%h pass=%b",
                 g, o.resp_done, o.pass_done, wr[g], wp[g]);
      end
      cmp++;
      if (o.busy_cnt != 16 * (HV[g] + 2) || o.done_cnt != 1 || o.done_at != 16 * (HV[g] + 2)) begin
        errs++;
        $display("FAIL spec_timing g=%0d got busy=%0d done=%0d at %0d want busy=%0d done=1 at %0d",
                 g, o.busy_cnt, o.done_cnt, o.done_at, 16 * (HV[g] + 2), 16 * (HV[g] + 2));
      end
      cmp++;
      if (o.qerr != 0 || o.overlap != 0) begin
        errs++;
        $display("FAIL spec_trace g=%0d got qerr=%0d overlap=%0d want 0 0", g, o.qerr, o.overlap);
      end
    end
  endtask

  task automatic test_random_sweeps();
    obs_t        o;
    int          g;
    logic [15:0] f, mdl, e;
    for (int it = 0; it < 6; it++) begin
      g   = $urandom_range(0, 2);
      f   = 16'($urandom);
      mdl = model(f, HV[g]);
      e   = ($urandom_range(0, 1) == 1) ? mdl : (mdl ^ (16'h0001 << $urandom_range(0, 15)));
      // abort landing in the DONE cycle must be ignored
      run(g, f, e, 1'b0, (it % 2 == 1) ? 16 * (HV[g] + 2) : -1, -1, o);
      cmp++;
      if (o.resp_done !== mdl || o.pass_done !== (mdl == e)) begin
        errs++;
        $display("FAIL rand_resp it=%0d g=%0d got resp=%h pass=%b want resp=%h pass=%b",
                 it, g, o.resp_done, o.pass_done, mdl, (mdl == e));
      end
      cmp++;
      if (o.s_resp !== mdl || o.s_pass !== (mdl == e) || o.done_cnt != 1 || o.qerr != 0) begin
        errs++;
        $display("FAIL rand_hold it=%0d g=%0d got idle resp=%h pass=%b done=%0d qerr=%0d want %h %b 1 0",
                 it, g, o.s_resp, o.s_pass, o.done_cnt, o.qerr, mdl, (mdl == e));
      end
    end
  endtask

  task automatic test_abort();
    obs_t        o;
    int          g, h, k, ph;
    logic [15:0] f, mk;
    run(0, spec_fn(), 16'h9180, 1'b0, 16, -1, o);
    cmp++;
    if (o.done_cnt != 0 || o.s_resp !== 16'h0000 || o.s_m !== 4'd5 || o.s_abcd !== 4'd5 ||
        o.s_pass !== 1'b0 || o.s_busy !== 1'b0 || o.busy_cnt != 17) begin
      errs++;
      $display("FAIL abort_m5 got done=%0d resp=%h m=%0d abcd=%0d pass=%b busy=%b busy_cnt=%0d want 0 0000 5 5 0 0 17",
               o.done_cnt, o.s_resp, o.s_m, o.s_abcd, o.s_pass, o.s_busy, o.busy_cnt);
    end
    for (int it = 0; it < 4; it++) begin
      g  = $urandom_range(0, 2);
      h  = HV[g];
      k  = (it == 3) ? 15 : $urandom_range(1, 14);
      ph = (it == 3) ? h + 1 : $urandom_range(0, h + 1);
      f  = 16'($urandom);
      mk = 16'((32'd1 << k) - 1);
      run(g, f, model(f, h), 1'b0, k * (h + 2) + ph, -1, o);
      cmp++;
      if (o.done_cnt != 0 || o.s_resp !== (model(f, h) & mk) || int'(o.s_m) != k ||
          o.s_pass !== 1'b0 || o.qerr != 0) begin
        errs++;
        $display("FAIL abort_rand g=%0d k=%0d ph=%0d got done=%0d resp=%h m=%0d pass=%b qerr=%0d want 0 %h %0d 0 0",
                 g, k, ph, o.done_cnt, o.s_resp, o.s_m, o.s_pass, o.qerr, model(f, h) & mk, k);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t        o;
    int          g = $urandom_range(0, 2);
    int          rc = 9 * (HV[g] + 2) + 1;
    logic [15:0] f = 16'($urandom);
    // coincident abort must not matter: reset wins
    run(g, f, model(f, HV[g]), 1'b0, rc, rc, o);
    cmp++;
    if ({o.s_resp, o.s_m, o.s_abcd, o.s_q, o.s_busy, o.s_done, o.s_pass} !== 31'd0 || o.done_cnt != 0) begin
      errs++;
      $display("FAIL reset_mid g=%0d got resp=%h m=%0d abcd=%0d q=%b busy=%b done=%b pass=%b dcnt=%0d want all 0",
               g, o.s_resp, o.s_m, o.s_abcd, o.s_q, o.s_busy, o.s_done, o.s_pass, o.done_cnt);
    end
    f = 16'($urandom);
    run(g, f, model(f, HV[g]), 1'b0, -1, -1, o);
    cmp++;
    if (o.resp_done !== model(f, HV[g]) || o.pass_done !== 1'b1 || o.done_cnt != 1 || o.qerr != 0) begin
      errs++;
      $display("FAIL reset_resweep g=%0d got resp=%h pass=%b done=%0d qerr=%0d want %h 1 1 0",
               g, o.resp_done, o.pass_done, o.done_cnt, o.qerr, model(f, HV[g]));
    end
  endtask

  task automatic test_back_to_back();
    obs_t        o;
    logic [15:0] f = 16'($urandom);
    run(0, f, model(f, 1), 1'b1, -1, -1, o);
    cmp++;
    if (o.busy_cnt != 48 || o.done_cnt != 1 || o.overlap != 0 || o.busy_late !== 1'b1 ||
        o.resp_done !== model(f, 1)) begin
      errs++;
      $display("FAIL b2b got busy=%0d done=%0d overlap=%0d restart=%b resp=%h want 48 1 0 1 %h",
               o.busy_cnt, o.done_cnt, o.overlap, o.busy_late, o.resp_done, model(f, 1));
    end
    start[0] = 1'b0; abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    @(posedge clk); #1;
    cmp++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errs++;
      $display("FAIL b2b_abort got busy=%b done=%b want 0 0", busy[0], done[0]);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      clr_n[g] = 1'b0; start[g] = 1'b0; abort[g] = 1'b0; expv[g] = '0; tbl[g] = '0;
    end
    test_reset();
    test_spec_sweeps();
    test_random_sweeps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
